// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                  |
// | Description : Dual-issue instruction fetch buffer fed by a 1-cycle ROM,    |
// |               with credit-style request reservation. Optional build macro  |
// |               FETCH_Q_NOP_SQUASH_EN drops all-zero ROM words on enqueue.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    output logic                         o_rom_en,
    input  logic [1:0][XLEN-1:0]         i_rom_insts,
    input  logic                         i_flush,
    output logic [1:0][XLEN-1:0]         o_insts,
    output logic [1:0]                   o_valid,
    input  logic [1:0]                   i_deq_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);
    localparam int                c_PTR_W      = $clog2(DEPTH);
    localparam int                c_CNT_W      = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0]  c_RESV_LIMIT = (c_CNT_W + 1)'(DEPTH - 2);

    logic [XLEN-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic               r_inflight;

    logic               w_live;
    logic               w_enq;
    logic [1:0]         w_deq_req;
    logic [1:0]         w_deq_eff;
    logic [1:0]         w_enq_n;
    logic               w_wr0;
    logic               w_wr1;
    logic [XLEN-1:0]    w_wr_data0;
    logic [c_CNT_W:0]   w_reserved;

    assign w_live = i_rst_n & ~i_flush;
    assign w_enq  = r_inflight & w_live;

    // Occupancy plus the pair already requested must leave room for another pair.
    assign w_reserved = {1'b0, r_count} + (r_inflight ? (c_CNT_W + 1)'(2) : '0);
    assign o_rom_en   = w_live & (w_reserved <= c_RESV_LIMIT);

    assign w_deq_req = (i_deq_cnt == 2'd3) ? 2'd2 : i_deq_cnt;
    assign w_deq_eff = (c_CNT_W'(w_deq_req) > r_count) ? r_count[1:0] : w_deq_req;

`ifdef FETCH_Q_NOP_SQUASH_EN
    logic w_nz0;
    logic w_nz1;

    assign w_nz0      = |i_rom_insts[0];
    assign w_nz1      = |i_rom_insts[1];
    // Surviving words are packed toward the tail in arrival order.
    assign w_wr0      = w_enq & (w_nz0 | w_nz1);
    assign w_wr1      = w_enq & w_nz0 & w_nz1;
    assign w_wr_data0 = w_nz0 ? i_rom_insts[0] : i_rom_insts[1];
    assign w_enq_n    = {1'b0, w_nz0} + {1'b0, w_nz1};
`else
    assign w_wr0      = w_enq;
    assign w_wr1      = w_enq;
    assign w_wr_data0 = i_rom_insts[0];
    assign w_enq_n    = 2'd2;
`endif

    always_ff @(posedge i_clk) begin
        if (w_wr0) begin
            r_mem[r_tail] <= w_wr_data0;
        end
        if (w_wr1) begin
            r_mem[r_tail + c_PTR_W'(1)] <= i_rom_insts[1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= o_rom_en;
            r_head     <= r_head + c_PTR_W'(w_deq_eff);
            if (w_enq) begin
                r_tail <= r_tail + c_PTR_W'(w_enq_n);
            end
            r_count <= r_count + (w_enq ? c_CNT_W'(w_enq_n) : '0) - c_CNT_W'(w_deq_eff);
        end
    end

    assign o_valid[0] = (r_count != '0);
    assign o_valid[1] = (r_count > c_CNT_W'(1));
    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);

    generate
        for (genvar g = 0; g < 2; g++) begin : g_out
            assign o_insts[g] = o_valid[g] ? r_mem[r_head + c_PTR_W'(g)] : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_queue                                               |
// | Description : Directed vector bench for fetch_queue with a 1-cycle ROM.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int NVEC  = 29;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic [1:0]  deq;
        logic        en;
        logic [1:0]  valid;
        logic [3:0]  cnt;
        logic [31:0] i0;
        logic [31:0] i1;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic [1:0]           deq = 2'd0;
    logic                 rom_en;
    logic [1:0][XLEN-1:0] rom_insts;
    logic [1:0][XLEN-1:0] insts;
    logic [1:0]           valid;
    logic [3:0]           count;
    logic                 empty;
    logic                 nop_mode = 1'b0;
    int                   req_cnt;

    int n_pass = 0;
    int n_total = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_rom_en    (rom_en),
        .i_rom_insts (rom_insts),
        .i_flush     (flush),
        .o_insts     (insts),
        .o_valid     (valid),
        .i_deq_cnt   (deq),
        .o_count     (count),
        .o_empty     (empty)
    );

    function automatic logic [1:0][XLEN-1:0] rom_word(input int k, input logic nop);
        logic [1:0][XLEN-1:0] w;
        if (!nop) begin
            w[0] = 32'(2 * k + 1);
            w[1] = 32'(2 * k + 2);
        end else if (k == 0) begin
            w[0] = 32'h0;
            w[1] = 32'hA;
        end else if (k == 1) begin
            w[0] = 32'hB;
            w[1] = 32'h0;
        end else begin
            w = '0;
        end
        return w;
    endfunction

    // ROM: answers each request one cycle later; junk otherwise so stray writes show up.
    always @(posedge clk) begin
        if (!rst_n) begin
            req_cnt   <= 0;
            rom_insts <= {32'hBAD1_BAD1, 32'hBAD0_BAD0};
        end else if (rom_en) begin
            rom_insts <= rom_word(req_cnt, nop_mode);
            req_cnt   <= req_cnt + 1;
        end else begin
            rom_insts <= {32'hBAD1_BAD1, 32'hBAD0_BAD0};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic [1:0] d,
                                input logic e, input logic [1:0] v, input logic [3:0] c,
                                input logic [31:0] a, input logic [31:0] b);
        vec_t t;
        t.rst_n = r; t.flush = f; t.deq = d; t.en = e;
        t.valid = v; t.cnt = c; t.i0 = a; t.i1 = b;
        return t;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_w;
        // rst flush deq | rom_en valid count inst0 inst1  (outputs before the edge)
        vecs[0]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 1, 2'b00, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 1, 2'b00, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 1, 2'b11, 2, 1, 2);
        vecs[6]  = mk(1, 0, 0, 1, 2'b11, 4, 1, 2);
        vecs[7]  = mk(1, 0, 0, 0, 2'b11, 6, 1, 2);
        vecs[8]  = mk(1, 0, 2, 0, 2'b11, 8, 1, 2);
        vecs[9]  = mk(1, 0, 2, 1, 2'b11, 6, 3, 4);
        vecs[10] = mk(1, 0, 2, 1, 2'b11, 4, 5, 6);
        vecs[11] = mk(1, 0, 2, 1, 2'b11, 4, 7, 8);
        vecs[12] = mk(1, 0, 2, 1, 2'b11, 4, 9, 10);
        vecs[13] = mk(1, 0, 2, 1, 2'b11, 4, 11, 12);
        vecs[14] = mk(1, 0, 1, 1, 2'b11, 4, 13, 14);
        vecs[15] = mk(1, 0, 0, 0, 2'b11, 5, 14, 15);
        vecs[16] = mk(1, 0, 2, 0, 2'b11, 7, 14, 15);
        vecs[17] = mk(1, 0, 2, 1, 2'b11, 5, 16, 17);
        vecs[18] = mk(1, 0, 1, 1, 2'b11, 3, 18, 19);
        vecs[19] = mk(1, 0, 3, 1, 2'b11, 4, 19, 20);
        vecs[20] = mk(1, 0, 2, 1, 2'b11, 4, 21, 22);
        vecs[21] = mk(1, 1, 2, 0, 2'b11, 4, 23, 24);
        vecs[22] = mk(1, 0, 0, 1, 2'b00, 0, 0, 0);
        vecs[23] = mk(1, 0, 2, 1, 2'b00, 0, 0, 0);
        vecs[24] = mk(1, 0, 1, 1, 2'b11, 2, 29, 30);
        vecs[25] = mk(0, 0, 0, 0, 2'b11, 3, 30, 31);
        vecs[26] = mk(1, 0, 0, 1, 2'b00, 0, 0, 0);
        vecs[27] = mk(1, 0, 0, 1, 2'b00, 0, 0, 0);
        vecs[28] = mk(1, 0, 0, 1, 2'b11, 2, 1, 2);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            flush = vecs[i].flush;
            deq   = vecs[i].deq;
            #1;
            check($sformatf("v%0d rom_en", i), 32'(rom_en), 32'(vecs[i].en));
            check($sformatf("v%0d valid", i), 32'(valid), 32'(vecs[i].valid));
            check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].cnt == 4'd0));
            check($sformatf("v%0d inst0", i), insts[0], vecs[i].i0);
            check($sformatf("v%0d inst1", i), insts[1], vecs[i].i1);
        end

        // Sustained dual dequeue: gap-free in-order words, request held high.
        exp_w = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rst_n = 1'b1;
            flush = 1'b0;
            deq   = 2'd2;
            #1;
            check($sformatf("stream%0d rom_en", k), 32'(rom_en), 32'd1);
            check($sformatf("stream%0d valid", k), 32'(valid), 32'd3);
            check($sformatf("stream%0d inst0", k), insts[0], 32'(exp_w));
            check($sformatf("stream%0d inst1", k), insts[1], 32'(exp_w + 1));
            exp_w += 2;
        end

        // ROM pairs {0,A},{B,0},{0,0} after a fresh reset, no dequeue.
        @(negedge clk);
        rst_n    = 1'b0;
        deq      = 2'd0;
        nop_mode = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
`ifdef FETCH_Q_NOP_SQUASH_EN
        check("nop count", 32'(count), 32'd2);
        check("nop inst0", insts[0], 32'hA);
        check("nop inst1", insts[1], 32'hB);
`else
        check("nop count", 32'(count), 32'd6);
        check("nop inst0", insts[0], 32'h0);
        check("nop inst1", insts[1], 32'hA);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
